// File: rtl/instr_word_encoder_pkg.sv
// Shared MIPS opcode/funct constants, request-kind codes and word builders.
// The HALT state is only present when INSTR_ENC_HALT_EN is defined.
package instr_word_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] KIND_ADD = 4'd0;
    localparam logic [3:0] KIND_SUB = 4'd1;
    localparam logic [3:0] KIND_AND = 4'd2;
    localparam logic [3:0] KIND_OR  = 4'd3;
    localparam logic [3:0] KIND_SLT = 4'd4;
    localparam logic [3:0] KIND_LW  = 4'd5;
    localparam logic [3:0] KIND_SW  = 4'd6;
    localparam logic [3:0] KIND_BEQ = 4'd7;
    localparam logic [3:0] KIND_J   = 4'd8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
`ifdef INSTR_ENC_HALT_EN
        StHalt = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/instr_word_encoder_field_packer.sv
// Combinational packer: request kind plus register/immediate fields into a 32-bit
// MIPS word; kinds outside ADD..J flag illegal and produce a zero word.
module instr_field_packer
    import instr_word_encoder_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_ADD: word_o = r_word(rs_i, rt_i, rd_i, FUNCT_ADD);
            KIND_SUB: word_o = r_word(rs_i, rt_i, rd_i, FUNCT_SUB);
            KIND_AND: word_o = r_word(rs_i, rt_i, rd_i, FUNCT_AND);
            KIND_OR:  word_o = r_word(rs_i, rt_i, rd_i, FUNCT_OR);
            KIND_SLT: word_o = r_word(rs_i, rt_i, rd_i, FUNCT_SLT);
            KIND_LW:  word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
            KIND_SW:  word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
            KIND_BEQ: word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
            KIND_J:   word_o = j_word(target_i);
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_word_encoder.sv
// Encodes symbolic instruction requests into MIPS words and streams them into
// instruction memory. Define INSTR_ENC_HALT_EN to append a J-to-self word on finish.
module instr_word_encoder
    import instr_word_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_kind_i,
    input  logic [4:0]        req_rs_i,
    input  logic [4:0]        req_rt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [15:0]       req_imm_i,
    input  logic [25:0]       req_target_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-3:0] word_count_o,
    output logic              err_illegal_o,
    output logic              err_wrap_o
);

    localparam int unsigned CntW = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = {{(ADDR_W - 2){1'b1}}, 2'b00};

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CntW-1:0]   count_q;
    logic              out_valid_q;
    logic [31:0]       wdata_q;
    logic              finish_q;
    logic              err_illegal_q;
    logic              err_wrap_q;

    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              accept;
    logic              wr_fire;
    logic              drained;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_after;

    instr_field_packer u_packer (
        .kind_i    (req_kind_i),
        .rs_i      (req_rs_i),
        .rt_i      (req_rt_i),
        .rd_i      (req_rd_i),
        .imm_i     (req_imm_i),
        .target_i  (req_target_i),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    assign req_ready_o = (state_q == StLoad) && !finish_q && (!out_valid_q || imem_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign wr_fire     = out_valid_q && imem_ready_i;
    // Once finish is latched no new words are loaded, so empty-after-this-edge is just this.
    assign drained     = !out_valid_q || imem_ready_i;
    assign addr_inc    = addr_q + ADDR_W'(4);
    assign addr_after  = wr_fire ? addr_inc : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= BaseAddr;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            wdata_q       <= '0;
            finish_q      <= 1'b0;
            err_illegal_q <= 1'b0;
            err_wrap_q    <= 1'b0;
        end else if (start_i) begin
            state_q       <= StLoad;
            addr_q        <= BaseAddr;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            finish_q      <= 1'b0;
            err_illegal_q <= 1'b0;
            err_wrap_q    <= 1'b0;
        end else begin
            if (wr_fire) begin
                addr_q      <= addr_inc;
                count_q     <= count_q + CntW'(1);
                out_valid_q <= 1'b0;
                if (addr_q == LastAddr) begin
                    err_wrap_q <= 1'b1;
                end
            end
            case (state_q)
                StLoad: begin
                    if (finish_i) begin
                        finish_q <= 1'b1;
                    end
                    if (accept) begin
                        if (pack_illegal) begin
                            err_illegal_q <= 1'b1;
                        end else begin
                            wdata_q     <= pack_word;
                            out_valid_q <= 1'b1;
                        end
                    end
                    if (finish_q && drained) begin
                        finish_q <= 1'b0;
`ifdef INSTR_ENC_HALT_EN
                        state_q     <= StHalt;
                        wdata_q     <= j_word(26'(addr_after >> 2));
                        out_valid_q <= 1'b1;
`else
                        state_q <= StDone;
`endif
                    end
                end
`ifdef INSTR_ENC_HALT_EN
                StHalt: begin
                    if (wr_fire) begin
                        state_q <= StDone;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef INSTR_ENC_HALT_EN
    assign busy_o = (state_q == StLoad) || (state_q == StHalt);
`else
    assign busy_o = (state_q == StLoad);
`endif
    assign done_o        = (state_q == StDone);
    assign imem_we_o     = out_valid_q;
    assign imem_addr_o   = addr_q;
    assign imem_wdata_o  = wdata_q;
    assign word_count_o  = count_q;
    assign err_illegal_o = err_illegal_q;
    assign err_wrap_o    = err_wrap_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: directed scenarios plus a randomized
// run against a queue-free behavioural model; honours INSTR_ENC_HALT_EN.
module tb_instr_word_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, finish, req_valid, imem_ready;
    logic [3:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;

    logic        req_ready, imem_we, busy, done, err_illegal, err_wrap;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [7:0]  word_count;

    logic        w_req_ready, w_we, w_busy, w_done, w_err_illegal, w_err_wrap;
    logic [3:0]  w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_word_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start_i(start), .finish_i(finish),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_kind_i(req_kind),
        .req_rs_i(req_rs), .req_rt_i(req_rt), .req_rd_i(req_rd), .req_imm_i(req_imm),
        .req_target_i(req_target), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
        .imem_wdata_o(imem_wdata), .imem_ready_i(imem_ready), .busy_o(busy), .done_o(done),
        .word_count_o(word_count), .err_illegal_o(err_illegal), .err_wrap_o(err_wrap)
    );

    instr_word_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst(rst), .start_i(start), .finish_i(finish),
        .req_valid_i(req_valid), .req_ready_o(w_req_ready), .req_kind_i(req_kind),
        .req_rs_i(req_rs), .req_rt_i(req_rt), .req_rd_i(req_rd), .req_imm_i(req_imm),
        .req_target_i(req_target), .imem_we_o(w_we), .imem_addr_o(w_addr),
        .imem_wdata_o(w_wdata), .imem_ready_i(imem_ready), .busy_o(w_busy), .done_o(w_done),
        .word_count_o(w_count), .err_illegal_o(w_err_illegal), .err_wrap_o(w_err_wrap)
    );

`ifdef INSTR_ENC_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    // Reference encoder built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int imm, input int target);
        longint unsigned w;
        int functs[5] = '{32, 34, 36, 37, 42};
        int ops[3] = '{35, 43, 4};
        w = 0;
        if (kind <= 4) w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
                           + longint'(functs[kind]);
        else if (kind <= 7) w = longint'(ops[kind - 5]) * 67108864 + longint'(rs) * 2097152
                                + longint'(rt) * 65536 + longint'(imm);
        else if (kind == 8) w = 2 * 67108864 + longint'(target);
        return w[31:0];
    endfunction

    task automatic drive_idle();
        start = 0; finish = 0; req_valid = 0; imem_ready = 1;
        req_kind = 0; req_rs = 0; req_rt = 0; req_rd = 0; req_imm = 0; req_target = 0;
    endtask

    task automatic set_req(input int kind, input int rs, input int rt, input int rd,
                           input int imm);
        req_valid = 1; req_kind = 4'(kind); req_rs = 5'(rs); req_rt = 5'(rt);
        req_rd = 5'(rd); req_imm = 16'(imm);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, word_count, busy, done, err_illegal, err_wrap,
             req_ready} !== {1'b0, 10'd0, 32'd0, 8'd0, 6'b0}) begin
            n_errors++;
            $display("FAIL reset_values: got we=%0b addr=%0d data=%h cnt=%0d busy=%0b done=%0b ei=%0b ew=%0b rdy=%0b, want all zero",
                     imem_we, imem_addr, imem_wdata, word_count, busy, done, err_illegal,
                     err_wrap, req_ready);
        end
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({busy, req_ready, imem_we} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy/rdy/we=%b want 000", {busy, req_ready, imem_we});
        end
    endtask

    task automatic test_add();
        do_start();
        n_checks++;
        if ({busy, req_ready} !== 2'b11) begin
            n_errors++;
            $display("FAIL start_busy_ready: got %b want 11", {busy, req_ready});
        end
        set_req(0, 1, 2, 3, 0);
        @(negedge clk); req_valid = 0;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h00221820}) begin
            n_errors++;
            $display("FAIL add_word: got we=%0b addr=%0d data=%h want 1/0/00221820",
                     imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({imem_we, word_count, imem_addr} !== {1'b0, 8'd1, 10'd4}) begin
            n_errors++;
            $display("FAIL add_count: got we=%0b cnt=%0d addr=%0d want 0/1/4",
                     imem_we, word_count, imem_addr);
        end
    endtask

    task automatic test_mem_ops();
        logic [31:0] exp_w[3] = '{32'h8C850010, 32'hAC850010, 32'h1022FFFF};
        do_start();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) set_req(7, 1, 2, 0, 16'hFFFF);
            else set_req(5 + k, 4, 5, 0, 16'h0010);
            @(negedge clk);
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(4 * k), exp_w[k]}) begin
                n_errors++;
                $display("FAIL mem_op%0d: got we=%0b addr=%0d data=%h want 1/%0d/%h",
                         k, imem_we, imem_addr, imem_wdata, 4 * k, exp_w[k]);
            end
        end
        req_valid = 0;
        @(negedge clk);
        n_checks++;
        if (word_count !== 8'd3) begin
            n_errors++;
            $display("FAIL mem_count: got %0d want 3", word_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w_or;
        w_or = ref_encode(3, 7, 8, 9, 0, 0);
        do_start();
        set_req(3, 7, 8, 9, 0); imem_ready = 0;
        @(negedge clk);
        set_req(0, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata, req_ready} !== {1'b1, 10'd0, w_or, 1'b0}) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got we=%0b addr=%0d data=%h rdy=%0b want 1/0/%h/0",
                         k, imem_we, imem_addr, imem_wdata, req_ready, w_or);
            end
            @(negedge clk);
        end
        imem_ready = 1; #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release_ready: got %0b want 1", req_ready);
        end
        @(negedge clk); req_valid = 0;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, word_count}
            !== {1'b1, 10'd4, ref_encode(0, 1, 1, 1, 0, 0), 8'd1}) begin
            n_errors++;
            $display("FAIL bp_after: got we=%0b addr=%0d data=%h cnt=%0d want 1/4/next/1",
                     imem_we, imem_addr, imem_wdata, word_count);
        end
        @(negedge clk);
        n_checks++;
        if (word_count !== 8'd2) begin
            n_errors++;
            $display("FAIL bp_once: got count %0d want 2", word_count);
        end
    endtask

    task automatic test_illegal();
        do_start();
        set_req(12, 1, 2, 3, 0);
        @(negedge clk); req_valid = 0;
        n_checks++;
        if ({err_illegal, imem_we, word_count} !== {1'b1, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL illegal_flag: got ei=%0b we=%0b cnt=%0d want 1/0/0",
                     err_illegal, imem_we, word_count);
        end
        set_req(4, 1, 2, 3, 0);
        @(negedge clk); req_valid = 0;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h0022182A}) begin
            n_errors++;
            $display("FAIL illegal_slt: got we=%0b addr=%0d data=%h want 1/0/0022182a",
                     imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({word_count, err_illegal} !== {8'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL illegal_sticky: got cnt=%0d ei=%0b want 1/1", word_count, err_illegal);
        end
    endtask

    task automatic test_wrap();
        do_start();
        for (int k = 0; k < 5; k++) begin
            set_req(1, k, 1, 2, 0);
            @(negedge clk);
            n_checks++;
            if ({w_we, w_addr, w_err_wrap} !== {1'b1, 4'((4 * k) % 16), (k == 4)}) begin
                n_errors++;
                $display("FAIL wrap%0d: got we=%0b addr=%0d ew=%0b want 1/%0d/%0b",
                         k, w_we, w_addr, w_err_wrap, (4 * k) % 16, (k == 4));
            end
        end
        req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_finish();
        do_start();
        set_req(0, 1, 2, 3, 0);
        @(negedge clk);
        set_req(1, 4, 5, 6, 0); finish = 1;
        @(negedge clk);
        finish = 0; req_valid = 0; #1;
        n_checks++;
        if ({imem_we, imem_addr, req_ready} !== {1'b1, 10'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL finish_second: got we=%0b addr=%0d rdy=%0b want 1/4/0",
                     imem_we, imem_addr, req_ready);
        end
        @(negedge clk);
        if (HaltEn) begin
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata, done} !== {1'b1, 10'd8, 32'h08000002, 1'b0}) begin
                n_errors++;
                $display("FAIL halt_word: got we=%0b addr=%0d data=%h done=%0b want 1/8/08000002/0",
                         imem_we, imem_addr, imem_wdata, done);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({done, busy, imem_we, word_count} !== {1'b1, 1'b0, 1'b0, HaltEn ? 8'd3 : 8'd2}) begin
            n_errors++;
            $display("FAIL finish_done: got done=%0b busy=%0b we=%0b cnt=%0d", done, busy,
                     imem_we, word_count);
        end
        set_req(0, 1, 1, 1, 0); #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL done_ignores: got rdy=%0b want 0", req_ready);
        end
        @(negedge clk); req_valid = 0;
        start = 1; finish = 1;
        @(negedge clk); start = 0; finish = 0; #1;
        n_checks++;
        if ({done, busy, req_ready, imem_addr, word_count}
            !== {1'b0, 1'b1, 1'b1, 10'd0, 8'd0}) begin
            n_errors++;
            $display("FAIL restart: got done=%0b busy=%0b rdy=%0b addr=%0d cnt=%0d want 0/1/1/0/0",
                     done, busy, req_ready, imem_addr, word_count);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b01) begin
            n_errors++;
            $display("FAIL start_beats_finish: got done/busy=%b want 01", {done, busy});
        end
    endtask

    task automatic test_reset_abort();
        do_start();
        set_req(2, 3, 3, 3, 0); imem_ready = 0;
        @(negedge clk); req_valid = 0;
        #2 rst = 1;
        #1;
        n_checks++;
        if ({imem_we, busy, word_count} !== {1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_abort: got we=%0b busy=%0b cnt=%0d want 0/0/0",
                     imem_we, busy, word_count);
        end
        @(negedge clk); rst = 0; imem_ready = 1;
    endtask

    task automatic test_random();
        bit m_pend, m_ill, m_wrap, exp_rdy, fire;
        logic [31:0] m_word;
        int m_addr, m_count, exp_final, kind;
        bit saw_done;
        m_pend = 0; m_ill = 0; m_wrap = 0; m_addr = 0; m_count = 0; m_word = 0;
        do_start();
        for (int c = 0; c < 700; c++) begin
            n_checks++;
            if ({imem_we, err_illegal, err_wrap, word_count, imem_addr}
                !== {m_pend, m_ill, m_wrap, 8'(m_count), 10'(m_addr)}) begin
                n_errors++;
                $display("FAIL rand_state c=%0d: got we=%0b ei=%0b ew=%0b cnt=%0d addr=%0d want %0b/%0b/%0b/%0d/%0d",
                         c, imem_we, err_illegal, err_wrap, word_count, imem_addr, m_pend,
                         m_ill, m_wrap, m_count % 256, m_addr);
            end
            if (m_pend) begin
                n_checks++;
                if (imem_wdata !== m_word) begin
                    n_errors++;
                    $display("FAIL rand_data c=%0d: got %h want %h", c, imem_wdata, m_word);
                end
            end
            kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15))
                                               : int'($urandom_range(0, 8));
            req_valid = 1'($urandom_range(0, 1));
            req_kind = 4'(kind);
            req_rs = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
            req_imm = 16'($urandom); req_target = 26'($urandom);
            imem_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !m_pend || imem_ready;
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL rand_ready c=%0d: got %0b want %0b", c, req_ready, exp_rdy);
            end
            fire = m_pend && imem_ready;
            if (fire) begin
                if (m_addr == 1020) m_wrap = 1;
                m_addr = (m_addr + 4) % 1024;
                m_count = (m_count + 1) % 256;
                m_pend = 0;
            end
            if (req_valid && exp_rdy) begin
                if (kind > 8) m_ill = 1;
                else begin
                    m_pend = 1;
                    m_word = ref_encode(kind, int'(req_rs), int'(req_rt), int'(req_rd),
                                        int'(req_imm), int'(req_target));
                end
            end
            @(negedge clk);
        end
        exp_final = (m_count + int'(m_pend) + int'(HaltEn)) % 256;
        req_valid = 0; imem_ready = 1; finish = 1;
        @(negedge clk); finish = 0;
        saw_done = 0;
        for (int t = 0; t < 10 && !saw_done; t++) begin
            if (done) saw_done = 1;
            else @(negedge clk);
        end
        n_checks++;
        if ({saw_done, word_count} !== {1'b1, 8'(exp_final)}) begin
            n_errors++;
            $display("FAIL rand_finish: got done=%0b cnt=%0d want 1/%0d", saw_done, word_count,
                     exp_final);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_add();
        test_mem_ops();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_finish();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
